seg7_scan_ctrl: RTL



---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-high, bit 0 = segment a.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int SEG_COUNT  = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Index 15 is leftmost: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][SEG_COUNT-1:0] SEG_ENC = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [SEG_COUNT-1:0] seg;
    logic                 dp;
  } seg_pat_t;

  typedef enum logic [1:0] {
    SLOT_GAP,
    SLOT_LIT,
    SLOT_DIM
  } slot_phase_e;

  function automatic logic [SEG_COUNT-1:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_ENC[nibble];
  endfunction

  function automatic logic [SEG_COUNT-1:0] apply_pol(input logic [SEG_COUNT-1:0] pat,
                                                     input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]           nibble,
  output logic [SEG_COUNT-1:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner; values double-buffered to frame boundaries, outputs registered.
// Brightness PWM on the anodes is built only when SEG7_SCAN_DIMMING_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 10000,
  parameter int GAP            = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    lzb_i,
`ifdef SEG7_SCAN_DIMMING_EN
  input  logic [3:0]              bright_i,
`endif
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GAP  = CW'(GAP);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || GAP < 1 || DIV < GAP + 16) begin : g_bad_params
    $error("seg7_scan_ctrl: illegal parameter combination");
  end

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          last_cnt;
  logic          boundary;

  assign last_cnt = (cnt == CNT_LAST);
  assign boundary = last_cnt && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (last_cnt) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  logic [4*NUM_DIGITS-1:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic                    pending;

  // A load on the boundary cycle bypasses the shadow so it shows in the very next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_val <= value_i;
        shadow_dp  <= dp_i;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load_i) begin
          active_val <= value_i;
          active_dp  <= dp_i;
        end else if (pending) begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
        end
      end else if (load_i) begin
        pending <= 1'b1;
      end
    end
  end

  logic [3:0] sel_nib;
  logic       sel_dp;
  logic       upper_zero;

  // upper_zero: the current digit and every more significant one hold 0.
  always_comb begin
    sel_nib    = 4'h0;
    sel_dp     = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        sel_nib = active_val[4*i +: 4];
        sel_dp  = active_dp[i];
      end
      if (IW'(i) >= idx && active_val[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
  end

  logic [SEG_COUNT-1:0] dec_seg;

  seg7_hex_decode u_hex_decode (
    .nibble (sel_nib),
    .seg    (dec_seg)
  );

  slot_phase_e phase;

`ifdef SEG7_SCAN_DIMMING_EN
  logic [3:0] pwm_pos;
  assign pwm_pos = 4'(cnt - CNT_GAP);
`endif

  always_comb begin
    phase = SLOT_GAP;
    if (cnt >= CNT_GAP) begin
`ifdef SEG7_SCAN_DIMMING_EN
      phase = (pwm_pos <= bright_i) ? SLOT_LIT : SLOT_DIM;
`else
      phase = SLOT_LIT;
`endif
    end
  end

  seg_pat_t              pat;
  logic [NUM_DIGITS-1:0] an_next;

  always_comb begin
    pat.seg = (lzb_i && idx != '0 && upper_zero) ? '0 : dec_seg;
    pat.dp  = sel_dp;
    an_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next[i] = (IW'(i) == idx) && (phase == SLOT_LIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_o   <= apply_pol('0, SEG_ACTIVE_LOW);
      dp_o    <= SEG_ACTIVE_LOW;
      an_o    <= AN_ACTIVE_LOW ? '1 : '0;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= apply_pol(pat.seg, SEG_ACTIVE_LOW);
      dp_o    <= SEG_ACTIVE_LOW ? ~pat.dp : pat.dp;
      an_o    <= AN_ACTIVE_LOW ? ~an_next : an_next;
      frame_o <= boundary;
    end
  end

endmodule
